// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage: state encoding, halt word,
// default geometry and the in-flight slot record.
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_HALTED = 2'd1,
    ST_FAULT  = 2'd2
  } fetch_state_e;

  localparam logic [31:0] HALT_WORD         = 32'h0000_0000;
  localparam int unsigned DEFAULT_MEM_DEPTH = 32'd128;
  localparam logic [31:0] DEFAULT_RESET_PC  = 32'h0000_0000;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic        oob;
  } slot_t;

  // Out-of-range check on a word address; wrapped addresses are still compared in full.
  function automatic logic addr_oob(input logic [31:0] addr, input logic [31:0] depth);
    return (addr >= depth);
  endfunction

endpackage

// File: rtl/fetch_hold_buf.sv
// Single-entry hold slot that parks the presented word while decode stalls.
// Clear wins over capture, capture wins over drop.
module fetch_hold_buf (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        capture,
  input  logic        drop,
  input  logic [31:0] cap_inst,
  input  logic [31:0] cap_pc,
  input  logic        cap_oob,
  output logic        hold_valid,
  output logic [31:0] hold_inst,
  output logic [31:0] hold_pc,
  output logic        hold_oob
);

  logic        valid_d, valid_q;
  logic [31:0] inst_d, inst_q;
  logic [31:0] pc_d, pc_q;
  logic        oob_d, oob_q;

  // Next-entry selection.
  always_comb begin
    valid_d = valid_q;
    inst_d  = inst_q;
    pc_d    = pc_q;
    oob_d   = oob_q;
    if (clear) begin
      valid_d = 1'b0;
    end else if (capture) begin
      valid_d = 1'b1;
      inst_d  = cap_inst;
      pc_d    = cap_pc;
      oob_d   = cap_oob;
    end else if (drop) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Slot storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      inst_q  <= 32'h0000_0000;
      pc_q    <= 32'h0000_0000;
      oob_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      inst_q  <= inst_d;
      pc_q    <= pc_d;
      oob_q   <= oob_d;
    end
  end

  assign hold_valid = valid_q;
  assign hold_inst  = inst_q;
  assign hold_pc    = pc_q;
  assign hold_oob   = oob_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, pairs memory words with their address,
// absorbs decode stalls, redirects on taken branches and stops on halt or fault.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned MEM_DEPTH    = DEFAULT_MEM_DEPTH,
  parameter logic [31:0] RESET_PC     = DEFAULT_RESET_PC,
  parameter bit          HALT_ON_ZERO = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] mem_inst,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] pc,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_valid,
  output logic        halted,
  output logic        fault
);

  localparam logic [31:0] DEPTH_W = 32'(MEM_DEPTH);

  fetch_state_e state_d, state_q;
  logic [31:0]  pc_d, pc_q;
  slot_t        mem_d, mem_q;

  logic        hold_valid, hold_oob;
  logic [31:0] hold_inst, hold_pc;

  logic        run, pres_valid, pres_oob, pres_ok;
  logic [31:0] pres_inst, pres_pc;
  logic        accept, halt_now, fault_now, redirect, capture, advance, hold_drop;

  // Presented entry and the per-cycle control decisions derived from it.
  always_comb begin
    run        = (state_q == ST_RUN);
    pres_valid = hold_valid | mem_q.valid;
    pres_inst  = hold_valid ? hold_inst : mem_inst;
    pres_pc    = hold_valid ? hold_pc   : mem_q.pc;
    pres_oob   = hold_valid ? hold_oob  : mem_q.oob;
    // An out-of-range entry is never handed to decode, stalled or not.
    pres_ok    = run & pres_valid & ~pres_oob;
    accept     = pres_ok & ~stall;
    halt_now   = accept & HALT_ON_ZERO & (pres_inst == HALT_WORD);
    fault_now  = run & pres_valid & pres_oob & ~stall;
    redirect   = accept & branch_taken & ~halt_now;
    capture    = run & stall & ~hold_valid & mem_q.valid;
    advance    = run & (~hold_valid | accept);
    hold_drop  = accept & hold_valid;
  end

  // Next-state logic for the run/halt/fault machine.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (halt_now) begin
          state_d = ST_HALTED;
        end else if (fault_now) begin
          state_d = ST_FAULT;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_HALTED: state_d = ST_HALTED;
      ST_FAULT:  state_d = ST_FAULT;
      default:   state_d = ST_FAULT;
    endcase
  end

  // PC and in-flight slot update.
  always_comb begin
    pc_d  = pc_q;
    mem_d = mem_q;
    if (redirect) begin
      pc_d        = branch_target;
      mem_d.valid = 1'b0;
    end else if (capture) begin
      // Refetch the same PC so the memory keeps returning the word held in flight.
      mem_d.valid = 1'b1;
      mem_d.pc    = pc_q;
      mem_d.oob   = addr_oob(pc_q, DEPTH_W);
    end else if (advance) begin
      mem_d.valid = 1'b1;
      mem_d.pc    = pc_q;
      mem_d.oob   = addr_oob(pc_q, DEPTH_W);
      pc_d        = pc_q + 32'd1;
    end else begin
      pc_d = pc_q;
    end
  end

  // State, PC and in-flight slot registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      pc_q        <= RESET_PC;
      mem_q.valid <= 1'b0;
      mem_q.pc    <= 32'h0000_0000;
      mem_q.oob   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      mem_q   <= mem_d;
    end
  end

  fetch_hold_buf u_hold (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (redirect),
    .capture    (capture),
    .drop       (hold_drop),
    .cap_inst   (mem_inst),
    .cap_pc     (mem_q.pc),
    .cap_oob    (mem_q.oob),
    .hold_valid (hold_valid),
    .hold_inst  (hold_inst),
    .hold_pc    (hold_pc),
    .hold_oob   (hold_oob)
  );

  assign pc         = pc_q;
  assign inst_valid = pres_ok;
  assign inst       = pres_ok ? pres_inst : 32'h0000_0000;
  assign inst_pc    = pres_pc;
  assign halted     = (state_q == ST_HALTED);
  assign fault      = (state_q == ST_FAULT);

endmodule
